// File: rtl/vx_mem_burst_model.sv
// Multi-port burst memory model: round-robin arbitration, configurable read
// latency, response backpressure, byte-enabled writes with a completion ack.
module vx_mem_burst_model #(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int TAG_WIDTH    = 8,
  parameter int BURST_LEN    = 8,
  parameter int DEPTH_BEATS  = 262144,
  parameter int READ_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              req_valid,
  output logic [NUM_PORTS-1:0]              req_ready,
  input  logic [NUM_PORTS-1:0]              req_rw,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_PORTS*TAG_WIDTH-1:0]    req_tag,
  input  logic [NUM_PORTS-1:0]              wdata_valid,
  output logic [NUM_PORTS-1:0]              wdata_ready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] wbyteen,
  output logic [NUM_PORTS-1:0]              rsp_valid,
  input  logic [NUM_PORTS-1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]             rsp_data,
  output logic [TAG_WIDTH-1:0]              rsp_tag,
  output logic                              rsp_last,
  output logic                              busy
);

  localparam int BE_WIDTH   = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = $clog2(BURST_LEN);
  localparam int SLOT_WIDTH = $clog2(DEPTH_BEATS / BURST_LEN);
  localparam int IDX_WIDTH  = SLOT_WIDTH + CNT_WIDTH;
  localparam int PORT_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WAIT_WIDTH = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
  localparam int WAIT_LAST  = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_BEAT,
    S_WR_BEAT,
    S_WR_ACK
  } state_t;

  state_t                state, state_nxt;
  logic [PORT_WIDTH-1:0] owner, last_grant, grant_idx, cand;
  logic                  grant_any;
  logic [SLOT_WIDTH-1:0] slot_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic [IDX_WIDTH-1:0]  beat_idx;
  logic [DATA_WIDTH-1:0] wdata_own;
  logic [BE_WIDTH-1:0]   be_own;
  logic                  accept, rd_hs, wr_hs, ack_hs, last_beat;
  logic                  addr_unused;

  // Zeroed once at time zero; reset deliberately leaves contents alone.
  logic [DATA_WIDTH-1:0] ram [DEPTH_BEATS] = '{default: '0};

  // Upper address bits only select aliases of the same slot.
  assign addr_unused = ^req_addr;

  assign beat_idx  = {slot_q, cnt};
  assign wdata_own = wdata[owner*DATA_WIDTH +: DATA_WIDTH];
  assign be_own    = wbyteen[owner*BE_WIDTH +: BE_WIDTH];
  assign last_beat = (cnt == CNT_WIDTH'(BURST_LEN - 1));
  assign accept    = (state == S_IDLE) && grant_any && !reset;
  assign rd_hs     = (state == S_RD_BEAT) && rsp_ready[owner];
  assign wr_hs     = (state == S_WR_BEAT) && wdata_valid[owner] && !reset;
  assign ack_hs    = (state == S_WR_ACK) && rsp_ready[owner];
  assign busy      = (state != S_IDLE);

  // Round-robin pick: first valid port after the last one granted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = PORT_WIDTH'((int'(last_grant) + i) % NUM_PORTS);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Grant is visible only in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // Next-state logic for the burst FSM.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_rw[grant_idx])     state_nxt = S_WR_BEAT;
          else if (READ_LATENCY > 1) state_nxt = S_RD_WAIT;
          else                       state_nxt = S_RD_BEAT;
        end
      end
      S_RD_WAIT: if (wait_cnt == WAIT_WIDTH'(WAIT_LAST)) state_nxt = S_RD_BEAT;
      S_RD_BEAT: if (rd_hs && last_beat)                 state_nxt = S_IDLE;
      S_WR_BEAT: if (wr_hs && last_beat)                 state_nxt = S_WR_ACK;
      S_WR_ACK:  if (ack_hs)                             state_nxt = S_IDLE;
      default:                                           state_nxt = S_IDLE;
    endcase
  end

  // Response and write-beat handshake outputs, driven only to the owner.
  always_comb begin
    rsp_valid   = '0;
    wdata_ready = '0;
    rsp_data    = '0;
    rsp_tag     = '0;
    rsp_last    = 1'b0;
    case (state)
      S_RD_BEAT: begin
        rsp_valid[owner] = 1'b1;
        rsp_data         = ram[beat_idx];
        rsp_tag          = tag_q;
        rsp_last         = last_beat;
      end
      S_WR_BEAT: wdata_ready[owner] = 1'b1;
      S_WR_ACK: begin
        rsp_valid[owner] = 1'b1;
        rsp_tag          = tag_q;
        rsp_last         = 1'b1;
      end
      default: ;
    endcase
  end

  // State, burst context, beat counter and latency counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state      <= S_IDLE;
      owner      <= '0;
      last_grant <= PORT_WIDTH'(NUM_PORTS - 1);
      slot_q     <= '0;
      tag_q      <= '0;
      cnt        <= '0;
      wait_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= grant_idx;
        last_grant <= grant_idx;
        slot_q     <= req_addr[grant_idx*ADDR_WIDTH +: SLOT_WIDTH];
        tag_q      <= req_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH];
        cnt        <= '0;
        wait_cnt   <= '0;
      end
      if (state == S_RD_WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (rd_hs || wr_hs)     cnt      <= cnt + 1'b1;
    end
  end

  // Byte-enabled RAM write of each accepted beat.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset branch; beats committed before a reset persist.
    if (wr_hs) begin
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (be_own[k]) ram[beat_idx][k*8 +: 8] <= wdata_own[k*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vx_mem_burst_model.sv
// Directed bench for vx_mem_burst_model: one instance with READ_LATENCY=1 and
// one with READ_LATENCY=4 sharing stimulus; use4 selects which one is driven.
module tb_vx_mem_burst_model;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int TW = 8;
  localparam int BL = 8;
  localparam int DB = 256;
  localparam int SLOTS = DB / BL;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic use4 = 1'b0;

  logic [NP-1:0]      req_valid_drv = '0;
  logic [NP-1:0]      req_rw = '0;
  logic [NP*AW-1:0]   req_addr = '0;
  logic [NP*TW-1:0]   req_tag = '0;
  logic [NP-1:0]      wdata_valid = '0;
  logic [NP*DW-1:0]   wdata = '0;
  logic [NP*DW/8-1:0] wbyteen = '0;
  logic [NP-1:0]      rsp_ready_drv = '1;

  logic [NP-1:0] req_valid_a, req_valid_b;
  logic [NP-1:0] req_ready_a, req_ready_b, wdata_ready_a, wdata_ready_b, rsp_valid_a, rsp_valid_b;
  logic [DW-1:0] rsp_data_a, rsp_data_b;
  logic [TW-1:0] rsp_tag_a, rsp_tag_b;
  logic          rsp_last_a, rsp_last_b, busy_a, busy_b;

  logic [NP-1:0] req_ready_m, wdata_ready_m, rsp_valid_m;
  logic [DW-1:0] rsp_data_m;
  logic [TW-1:0] rsp_tag_m;
  logic          rsp_last_m, busy_m;

  int checks = 0;
  int errors = 0;

  logic [63:0] seq_a [8];
  logic [63:0] seq_f [8];
  logic [63:0] seq_h [8];
  logic [63:0] seq_r [8];

  always #5 clk = ~clk;

  assign req_valid_a = use4 ? '0 : req_valid_drv;
  assign req_valid_b = use4 ? req_valid_drv : '0;
  assign req_ready_m   = use4 ? req_ready_b   : req_ready_a;
  assign wdata_ready_m = use4 ? wdata_ready_b : wdata_ready_a;
  assign rsp_valid_m   = use4 ? rsp_valid_b   : rsp_valid_a;
  assign rsp_data_m    = use4 ? rsp_data_b    : rsp_data_a;
  assign rsp_tag_m     = use4 ? rsp_tag_b     : rsp_tag_a;
  assign rsp_last_m    = use4 ? rsp_last_b    : rsp_last_a;
  assign busy_m        = use4 ? busy_b        : busy_a;

  vx_mem_burst_model #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .BURST_LEN(BL), .DEPTH_BEATS(DB), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_rw(req_rw),
    .req_addr(req_addr), .req_tag(req_tag),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready_a), .wdata(wdata), .wbyteen(wbyteen),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_drv), .rsp_data(rsp_data_a),
    .rsp_tag(rsp_tag_a), .rsp_last(rsp_last_a), .busy(busy_a)
  );

  vx_mem_burst_model #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .BURST_LEN(BL), .DEPTH_BEATS(DB), .READ_LATENCY(4)
  ) dut4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_rw(req_rw),
    .req_addr(req_addr), .req_tag(req_tag),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready_b), .wdata(wdata), .wbyteen(wbyteen),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_drv), .rsp_data(rsp_data_b),
    .rsp_tag(rsp_tag_b), .rsp_last(rsp_last_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic rw, input logic [31:0] addr, input logic [7:0] tag);
    req_rw[p]            = rw;
    req_addr[p*AW +: AW] = addr;
    req_tag[p*TW +: TW]  = tag;
  endtask

  // Raise req_valid on port p and wait (bounded) for its grant; the grant
  // edge is the next rising edge after return.
  task automatic wait_grant(input int p);
    int n = 0;
    req_valid_drv[p] = 1'b1;
    #1;
    while (!req_ready_m[p] && n < 40) begin
      tick();
      #1;
      n++;
    end
    check("grant", 64'(req_ready_m[p]), 64'(1));
  endtask

  task automatic write_burst(input int p, input logic [31:0] addr, input logic [7:0] tag,
                             input logic [63:0] beats [8], input logic [7:0] be);
    set_req(p, 1'b1, addr, tag);
    wait_grant(p);
    tick();
    req_valid_drv[p] = 1'b0;
    for (int b = 0; b < BL; b++) begin
      wdata[p*DW +: DW]        = beats[b];
      wbyteen[p*DW/8 +: DW/8]  = be;
      wdata_valid[p]           = 1'b1;
      #1;
      check("wr_ready", 64'(wdata_ready_m), 64'(1 << p));
      check("wr_busy", 64'(busy_m), 64'(1));
      tick();
    end
    wdata_valid[p] = 1'b0;
    #1;
    check("ack_valid", 64'(rsp_valid_m), 64'(1 << p));
    check("ack_data", rsp_data_m, 64'(0));
    check("ack_last", 64'(rsp_last_m), 64'(1));
    check("ack_tag", 64'(rsp_tag_m), 64'(tag));
    tick();
    check("wr_idle", 64'(busy_m), 64'(0));
  endtask

  task automatic read_burst(input int p, input logic [31:0] addr, input logic [7:0] tag,
                            input logic [63:0] exp [8], input int lat);
    int n = 1;
    set_req(p, 1'b0, addr, tag);
    wait_grant(p);
    tick();
    req_valid_drv[p] = 1'b0;
    #1;
    while (!rsp_valid_m[p] && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("rd_latency", 64'(n), 64'(lat));
    for (int b = 0; b < BL; b++) begin
      check("rd_valid", 64'(rsp_valid_m), 64'(1 << p));
      check("rd_data", rsp_data_m, exp[b]);
      check("rd_last", 64'(rsp_last_m), 64'(b == BL - 1));
      check("rd_tag", 64'(rsp_tag_m), 64'(tag));
      tick();
    end
    check("rd_bubble", 64'(busy_m), 64'(0));
  endtask

  initial begin
    for (int b = 0; b < BL; b++) begin
      seq_a[b] = 64'(8'h11 * (b + 1));
      seq_f[b] = 64'h0000_0000_FFFF_FFFF;
      seq_h[b] = 64'h100 + 64'(b);
      seq_r[b] = (b < 4) ? 64'h100 + 64'(b) : 64'h0;
    end

    // Reset: req_ready must stay low while reset is held even with a request up.
    tick();
    tick();
    req_valid_drv = 2'b01;
    #1;
    check("rst_req_ready", 64'(req_ready_m), 64'(0));
    req_valid_drv = 2'b00;
    reset = 1'b0;
    #1;
    check("rst_busy", 64'(busy_m), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid_m), 64'(0));
    check("rst_wdata_ready", 64'(wdata_ready_m), 64'(0));
    check("rst_rsp_last", 64'(rsp_last_m), 64'(0));
    check("rst_rsp_data", rsp_data_m, 64'(0));
    check("rst_rsp_tag", 64'(rsp_tag_m), 64'(0));
    tick();

    // Full write then read-back on port 0.
    write_burst(0, 32'd3, 8'h5A, seq_a, 8'hFF);
    read_burst(0, 32'd3, 8'h33, seq_a, 1);

    // Partial byte enables over zeroed RAM, port 1.
    write_burst(1, 32'd5, 8'h77, '{default: 64'hFFFF_FFFF_FFFF_FFFF}, 8'h0F);
    read_burst(1, 32'd5, 8'h78, seq_f, 1);

    // Address wrap: slot SLOTS+3 aliases slot 3.
    read_burst(0, 32'(SLOTS + 3), 8'h34, seq_a, 1);

    // Re-reset so port 0 has priority again; RAM contents survive.
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Both ports request continuously: grants alternate starting with port 0.
    set_req(0, 1'b0, 32'd3, 8'h10);
    set_req(1, 1'b0, 32'd5, 8'h21);
    req_valid_drv = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      while (req_ready_m == '0 && n < 40) begin
        tick();
        #1;
        n++;
      end
      check("arb_wait", 64'(n), 64'(0));
      check("arb_grant", 64'(req_ready_m), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      check("arb_pending", 64'(req_ready_m), 64'(0));
      check("arb_owner", 64'(rsp_valid_m), (k % 2 == 0) ? 64'h1 : 64'h2);
      check("arb_data", rsp_data_m, (k % 2 == 0) ? 64'h11 : 64'h0000_0000_FFFF_FFFF);
      check("arb_tag", 64'(rsp_tag_m), (k % 2 == 0) ? 64'h10 : 64'h21);
      for (int b = 0; b < BL; b++) tick();
    end
    req_valid_drv = 2'b00;
    tick();

    // Reset on beat 4 of a write; port 1 drives stray write beats meanwhile.
    set_req(0, 1'b1, 32'd7, 8'h44);
    wait_grant(0);
    tick();
    req_valid_drv[0] = 1'b0;
    wdata[DW +: DW]     = 64'hDEAD_BEEF_DEAD_BEEF;
    wbyteen[DW/8 +: DW/8] = 8'hFF;
    wdata_valid[1]      = 1'b1;
    wbyteen[0 +: DW/8]  = 8'hFF;
    for (int b = 0; b < 4; b++) begin
      wdata[0 +: DW] = seq_h[b];
      wdata_valid[0] = 1'b1;
      #1;
      check("nonowner_wready", 64'(wdata_ready_m), 64'h1);
      tick();
    end
    wdata[0 +: DW] = seq_h[4];
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wdata_valid = 2'b00;
    #1;
    check("abort_busy", 64'(busy_m), 64'(0));
    check("abort_rsp_valid", 64'(rsp_valid_m), 64'(0));
    check("abort_wdata_ready", 64'(wdata_ready_m), 64'(0));
    check("abort_req_ready", 64'(req_ready_m), 64'(0));
    read_burst(0, 32'd7, 8'h45, seq_r, 1);
    // Port 1's stray beats must not have landed at its own last address (slot 5).
    read_burst(1, 32'd5, 8'h79, seq_f, 1);

    // READ_LATENCY=4 instance with rsp_ready pattern 1,0,0,1,0,0,...
    use4 = 1'b1;
    #1;
    write_burst(0, 32'd3, 8'h66, seq_a, 8'hFF);
    begin
      int n = 1;
      int b = 0;
      int c = 0;
      set_req(0, 1'b0, 32'd3, 8'h67);
      wait_grant(0);
      tick();
      req_valid_drv[0] = 1'b0;
      #1;
      while (!rsp_valid_m[0] && n < 20) begin
        tick();
        #1;
        n++;
      end
      check("lat4_first", 64'(n), 64'(4));
      while (b < BL && c < 60) begin
        rsp_ready_drv[0] = (c % 3 == 0);
        #1;
        check("lat4_valid", 64'(rsp_valid_m), 64'h1);
        check("lat4_data", rsp_data_m, seq_a[b]);
        check("lat4_tag", 64'(rsp_tag_m), 64'h67);
        check("lat4_last", 64'(rsp_last_m), 64'(b == BL - 1));
        if (rsp_ready_drv[0]) b++;
        tick();
        c++;
      end
      check("lat4_beats", 64'(b), 64'(BL));
      rsp_ready_drv = '1;
      #1;
      check("lat4_idle", 64'(busy_m), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_mem_burst_model.md
# vx_mem_burst_model

Parametrised multi-port burst memory model for testbenches. It accepts burst read/write requests from NUM_PORTS requesters and serves them one at a time from a single zero-initialised RAM. It provides round-robin arbitration, configurable read latency, response backpressure, byte-enabled writes and a write-completion response. It sits directly on the Vortex memory request/response interface and bypasses the AXI/AHB bridge for code/data loading and simulation.

## Interface
- NUM_PORTS, 2, number of requester ports (≥1)
- ADDR_WIDTH, 32, request address width; one address unit = one burst
- DATA_WIDTH, 64, beat width; multiple of 8
- TAG_WIDTH, 8, request tag width
- BURST_LEN, 8, beats per burst; power of 2, ≥2
- DEPTH_BEATS, 262144, RAM depth in beats; power of 2, multiple of BURST_LEN
- READ_LATENCY, 1, cycles from read accept to first rsp_valid (≥1)
- clk  in  1  clock
- reset  in  1  Synchronous, active-high reset. Clock is clk.
- req_valid  in  NUM_PORTS  request valid per port
- req_ready  out  NUM_PORTS  request accepted when valid & ready
- req_rw  in  NUM_PORTS  1 = write, 0 = read
- req_addr  in  NUM_PORTS*ADDR_WIDTH  burst address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_tag  in  NUM_PORTS*TAG_WIDTH  request tag
- wdata_valid  in  NUM_PORTS  write beat valid
- wdata_ready  out  NUM_PORTS  write beat accepted when valid & ready
- wdata  in  NUM_PORTS*DATA_WIDTH  write beat data
- wbyteen  in  NUM_PORTS*DATA_WIDTH/8  byte enables; bit k covers byte k
- rsp_valid  out  NUM_PORTS  one-hot response valid (owner port only)
- rsp_ready  in  NUM_PORTS  response accept per port
- rsp_data  out  DATA_WIDTH  shared response data
- rsp_tag  out  TAG_WIDTH  tag of current burst
- rsp_last  out  1  final beat of read burst / write ack
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states and transitions:
  - IDLE → RD_WAIT (read accepted, READ_LATENCY>1) or RD_BEAT (READ_LATENCY=1), or WR_BEAT (write accepted).
  - RD_WAIT → RD_BEAT after READ_LATENCY−1 cycles.
  - RD_BEAT → IDLE on the last-beat handshake.
  - WR_BEAT → WR_ACK on the last accepted beat.
  - WR_ACK → IDLE on the ack handshake.
- Arbitration (IDLE only):
  - Round-robin over valid ports, starting at last-granted+1. After reset, port 0 has highest priority.
  - req_ready = grant one-hot, asserted only in IDLE and only to the granted valid port.
  - Accept latches owner, rw, addr and tag, and clears the beat counter cnt.
  - Requesters hold req_valid and payload stable until accepted.
- Addressing:
  - Beat index = {addr[log2(DEPTH_BEATS/BURST_LEN)-1:0], cnt}.
  - Upper address bits are ignored, so addresses wrap modulo DEPTH_BEATS/BURST_LEN.
- Read:
  - In RD_BEAT, rsp_valid[owner]=1 and rsp_data = ram[index].
  - cnt increments on rsp_valid & rsp_ready.
  - rsp_last=1 when cnt=BURST_LEN−1.
- Write:
  - In WR_BEAT, wdata_ready[owner]=1; all other ports read 0.
  - On each accepted beat, bytes with wbyteen=1 are written to ram[index] and cnt increments.
  - In WR_ACK, rsp_valid[owner]=1, rsp_data=0, rsp_last=1, rsp_tag=latched tag.
- rsp_data, rsp_tag and rsp_last hold stable while rsp_valid & !rsp_ready.
- RAM is zeroed at time zero and is not cleared by reset.
- cnt is log2(BURST_LEN) bits and wraps only at burst end.

## Timing
- Reset values: all req_ready, wdata_ready and rsp_valid = 0; rsp_last=0; rsp_data=0; rsp_tag=0; busy=0; state IDLE; cnt 0; rr pointer → port 0 highest priority.
- req_ready is forced 0 while reset is high.
- Read accepted at edge T:
  - First rsp_valid in cycle T+READ_LATENCY.
  - With rsp_ready held high, beats arrive on consecutive cycles.
  - req_ready reasserts in the cycle after the last-beat handshake, giving one idle bubble between bursts.
- Write accepted at T:
  - wdata_ready from T+1.
  - Last beat at W → ack rsp_valid in W+1.
- wdata_valid low or rsp_ready low stalls the counter; there is no timeout.
- Simultaneous requests: exactly one grant per IDLE cycle.
- A non-owner's requests stay pending with req_ready=0.
- Reset mid-burst: the burst is aborted and writes already committed persist. Next cycle after reset release: IDLE, no stray rsp_valid.
- wdata_valid on a non-owner port is ignored.

## Test plan
- Port 0 writes addr 3, beats 0x11..0x88, wbyteen all-ones, then reads addr 3 → 8 beats 0x11..0x88, rsp_last on beat 8 only, tag echoed, write ack rsp_data=0 with rsp_last=1.
- Write addr 5 with wbyteen=0x0F, data 0xFFFF_FFFF_FFFF_FFFF over zeroed RAM → read beats = 0x0000_0000_FFFF_FFFF.
- Both ports request continuously → grants alternate 0,1,0,1; neither port waits more than one burst.
- READ_LATENCY=4, rsp_ready toggling 1,0,0,1,… → first rsp_valid 4 cycles after accept; data and tag stable during stalls; 8 beats total, in order.
- Read of addr DEPTH_BEATS/BURST_LEN+3 → same data as addr 3 (wrap).
- Reset asserted on beat 4 of a write → busy=0 and all valid/ready outputs 0 after reset; reading back shows beats 0–3 written and beats 4–7 zero.
